// File: rtl/max_reducer_pkg.sv
// -----------------------------------------------------------------------------
// max_reducer_pkg
// Shared types and constants for the max_frame_reducer block.
//   state_e   : frame FSM state (ST_IDLE, ST_ACCUM)
//   result_t  : published result beat (max, idx, count, ovf, plus min fields
//               when MAX_REDUCER_MIN_EN is defined)
//   pos_sat() : saturation value of an idx_w-bit position counter
// Optional feature macro: MAX_REDUCER_MIN_EN (adds min tracking fields).
// -----------------------------------------------------------------------------
package max_reducer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Widest WIDTH / IDX_W the result struct can carry. Narrower instances
  // zero-extend into it and slice back out at the ports.
  localparam int unsigned RES_W = 32;

  // Largest value an idx_w-bit position counter can hold.
  function automatic int unsigned pos_sat(input int unsigned idx_w);
    return (idx_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << idx_w) - 32'd1);
  endfunction

  localparam int unsigned IDX_W_DEF   = 8;
  localparam int unsigned POS_SAT_DEF = pos_sat(IDX_W_DEF);

  typedef struct packed {
    logic [RES_W-1:0] max_val;
    logic [RES_W-1:0] max_idx;
    logic [RES_W-1:0] count;
    logic             ovf;
`ifdef MAX_REDUCER_MIN_EN
    logic [RES_W-1:0] min_val;
    logic [RES_W-1:0] min_idx;
`endif
  } result_t;

endpackage

// File: rtl/max_cmp_sel.sv
// -----------------------------------------------------------------------------
// max_cmp_sel
// Combinational strict-greater compare with value/index select.
//   o_val/o_idx = (i_lhs > i_rhs) ? i_new_val/i_new_idx : i_old_val/i_old_idx
// Used for max tracking (lhs = incoming word, rhs = current max) and, with the
// compare operands swapped, for min tracking (lhs = current min, rhs = word).
// Strict compare means equal values never replace: the earliest position wins.
// Ports:
//   i_lhs, i_rhs         : compare operands (unsigned, WIDTH)
//   i_new_val, i_new_idx : candidate taken when i_lhs > i_rhs
//   i_old_val, i_old_idx : value kept otherwise
//   o_val, o_idx         : selected value / index
// -----------------------------------------------------------------------------
module max_cmp_sel #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 8
) (
  input  logic [WIDTH-1:0] i_lhs,
  input  logic [WIDTH-1:0] i_rhs,
  input  logic [WIDTH-1:0] i_new_val,
  input  logic [IDX_W-1:0] i_new_idx,
  input  logic [WIDTH-1:0] i_old_val,
  input  logic [IDX_W-1:0] i_old_idx,
  output logic [WIDTH-1:0] o_val,
  output logic [IDX_W-1:0] o_idx
);

  logic w_take;

  assign w_take = (i_lhs > i_rhs);
  assign o_val  = w_take ? i_new_val : i_old_val;
  assign o_idx  = w_take ? i_new_idx : i_old_idx;

endmodule

// File: rtl/max_frame_reducer.sv
// -----------------------------------------------------------------------------
// max_frame_reducer
// Streaming per-frame reduction: tracks the running maximum of an unsigned
// valid/ready stream and the zero-based position of its first occurrence,
// then emits one registered result beat when the in_last beat is accepted.
// Optional feature macro: MAX_REDUCER_MIN_EN adds parallel min tracking and
// the out_min / out_min_idx ports.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake; in_ready = ~out_valid | out_ready
//   in_data, in_last      : input word, end-of-frame marker
//   out_valid/out_ready   : result handshake; result held until consumed
//   out_max, out_idx      : frame maximum and its first position
//   out_count             : beats in frame, saturating at 2^IDX_W-1
//   out_ovf               : frame was longer than 2^IDX_W-1 beats
//   out_min, out_min_idx  : frame minimum and first position (macro only)
// WIDTH and IDX_W must not exceed max_reducer_pkg::RES_W.
// -----------------------------------------------------------------------------
module max_frame_reducer
  import max_reducer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
`ifdef MAX_REDUCER_MIN_EN
 ,output logic [WIDTH-1:0] out_min,
  output logic [IDX_W-1:0] out_min_idx
`endif
);

  localparam logic [IDX_W-1:0] POS_SAT = IDX_W'(pos_sat(IDX_W));

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_cur_max;
  logic [IDX_W-1:0] r_cur_idx;
  logic [IDX_W-1:0] r_pos;       // position the next accepted beat will take
  logic             r_ovf;
  logic             r_out_valid;
  result_t          r_res;

  logic             w_accept;
  logic             w_pos_sat;
  logic [WIDTH-1:0] w_cmp_max;
  logic [IDX_W-1:0] w_cmp_idx;
  logic [WIDTH-1:0] w_nxt_max;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [IDX_W-1:0] w_nxt_pos;
  logic             w_nxt_ovf;
  result_t          w_res_nxt;
  logic             w_unused;

`ifdef MAX_REDUCER_MIN_EN
  logic [WIDTH-1:0] r_cur_min;
  logic [IDX_W-1:0] r_cur_min_idx;
  logic [WIDTH-1:0] w_cmp_min;
  logic [IDX_W-1:0] w_cmp_min_idx;
  logic [WIDTH-1:0] w_nxt_min;
  logic [IDX_W-1:0] w_nxt_min_idx;
`endif

  // A frame end may not overwrite an unconsumed result; mid-frame beats stall
  // too, which keeps in_ready a function of the output handshake only.
  assign in_ready  = ~r_out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_pos_sat = (r_pos == POS_SAT);

  max_cmp_sel #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_max_sel (
    .i_lhs     (in_data),
    .i_rhs     (r_cur_max),
    .i_new_val (in_data),
    .i_new_idx (r_pos),
    .i_old_val (r_cur_max),
    .i_old_idx (r_cur_idx),
    .o_val     (w_cmp_max),
    .o_idx     (w_cmp_idx)
  );

`ifdef MAX_REDUCER_MIN_EN
  // Operands swapped: replaces when cur_min > in_data, i.e. strict less-than.
  max_cmp_sel #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_min_sel (
    .i_lhs     (r_cur_min),
    .i_rhs     (in_data),
    .i_new_val (in_data),
    .i_new_idx (r_pos),
    .i_old_val (r_cur_min),
    .i_old_idx (r_cur_min_idx),
    .o_val     (w_cmp_min),
    .o_idx     (w_cmp_min_idx)
  );
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_nxt_max   = r_cur_max;
    w_nxt_idx   = r_cur_idx;
    w_nxt_pos   = r_pos;
    w_nxt_ovf   = r_ovf;
`ifdef MAX_REDUCER_MIN_EN
    w_nxt_min     = r_cur_min;
    w_nxt_min_idx = r_cur_min_idx;
`endif
    if (w_accept) begin
      if (r_state == ST_IDLE) begin
        // First beat of a frame seeds the trackers unconditionally.
        w_nxt_max = in_data;
        w_nxt_idx = '0;
        w_nxt_pos = IDX_W'(1);
        w_nxt_ovf = 1'b0;
`ifdef MAX_REDUCER_MIN_EN
        w_nxt_min     = in_data;
        w_nxt_min_idx = '0;
`endif
      end else begin
        w_nxt_max = w_cmp_max;
        w_nxt_idx = w_cmp_idx;
        // Counter sticks at saturation; any attempted step past it flags ovf.
        w_nxt_pos = w_pos_sat ? r_pos : r_pos + 1'b1;
        w_nxt_ovf = r_ovf | w_pos_sat;
`ifdef MAX_REDUCER_MIN_EN
        w_nxt_min     = w_cmp_min;
        w_nxt_min_idx = w_cmp_min_idx;
`endif
      end
      w_state_nxt = in_last ? ST_IDLE : ST_ACCUM;
    end

    w_res_nxt         = '0;
    w_res_nxt.max_val = RES_W'(w_nxt_max);
    w_res_nxt.max_idx = RES_W'(w_nxt_idx);
    w_res_nxt.count   = RES_W'(w_nxt_pos);
    w_res_nxt.ovf     = w_nxt_ovf;
`ifdef MAX_REDUCER_MIN_EN
    w_res_nxt.min_val = RES_W'(w_nxt_min);
    w_res_nxt.min_idx = RES_W'(w_nxt_min_idx);
`endif
  end

  // NOTE: flops use non-blocking (<=) so every register samples the values
  // from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_max <= '0;
      r_cur_idx <= '0;
      r_pos     <= '0;
      r_ovf     <= 1'b0;
`ifdef MAX_REDUCER_MIN_EN
      r_cur_min     <= '0;
      r_cur_min_idx <= '0;
`endif
    end else begin
      r_cur_max <= w_nxt_max;
      r_cur_idx <= w_nxt_idx;
      r_pos     <= w_nxt_pos;
      r_ovf     <= w_nxt_ovf;
`ifdef MAX_REDUCER_MIN_EN
      r_cur_min     <= w_nxt_min;
      r_cur_min_idx <= w_nxt_min_idx;
`endif
    end
  end

  // Result register: a frame end reloads it even while the previous result is
  // being consumed in the same cycle, so back-to-back frames have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else if (w_accept && in_last) begin
      r_out_valid <= 1'b1;
      r_res       <= w_res_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_max   = r_res.max_val[WIDTH-1:0];
  assign out_idx   = r_res.max_idx[IDX_W-1:0];
  assign out_count = r_res.count[IDX_W-1:0];
  assign out_ovf   = r_res.ovf;
`ifdef MAX_REDUCER_MIN_EN
  assign out_min     = r_res.min_val[WIDTH-1:0];
  assign out_min_idx = r_res.min_idx[IDX_W-1:0];
`endif

  // Upper bits of the zero-extended result fields are constant and unread.
  assign w_unused = ^r_res;

endmodule
